dc_offset_remover: RTL and testbench
====================================

DC_OFFSET_REMOVER -- requirements
Module: dc_offset_remover

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: width of the ADC sample and of the output sample.
REQ-002 SHALL have parameter BLOCK_LOG2, default 10: log2 of the mean-estimation block length (1024 samples).
REQ-003 SHALL have port clk, input, 1, the single 200MHz system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-005 SHALL have port adc_data, input, DATA_WIDTH, unsigned offset-binary ADC sample, already in the clk domain.
REQ-006 SHALL have port adc_valid, input, 1, one-clk strobe marking adc_data valid; arbitrary spacing, back-to-back allowed.
REQ-007 SHALL have port data_out, output, DATA_WIDTH, signed DC-removed sample, held between updates.
REQ-008 SHALL have port out_valid, output, 1, one-clk pulse marking a new data_out.
REQ-009 SHALL have port en, output, 1, high once a DC estimate exists; feeds the autocorrelation stage enable.
REQ-010 SHALL have port mean_out, output, DATA_WIDTH, current DC estimate, unsigned.
REQ-011 SHALL have port sat_flag, output, 1, sticky flag: some output saturated since reset.

Function
REQ-012 SHALL count accepted samples with a BLOCK_LOG2-bit counter, advanced only on adc_valid, wrapping 1023->0.
REQ-013 SHALL accumulate accepted samples into an unsigned sum of DATA_WIDTH+BLOCK_LOG2 bits (22 bits); overflow is impossible.
REQ-014 SHALL, on the adc_valid that brings the counter to 1023, register mean = (sum + that sample) >> BLOCK_LOG2 (floor, no rounding) and clear the sum to 0 in the same cycle.
REQ-015 SHALL run two states: ACQ (after reset, en=0) and RUN (en=1); ACQ->RUN on the first mean update; RUN has no exit except rst.
REQ-016 SHALL, in ACQ, keep data_out=0 and out_valid=0, while still accumulating samples.
REQ-017 SHALL, in RUN, on each adc_valid compute diff = adc_data - mean as a (DATA_WIDTH+1)-bit signed value, then register data_out and pulse out_valid on the next clk (latency 1 clk).
REQ-018 SHALL saturate diff to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] (-2048..2047); any clamp sets sat_flag, which stays set until rst.
REQ-019 SHALL subtract the mean registered before the current cycle; a sample that completes a block uses the old mean, and the new mean applies from the next sample.
REQ-020 SHALL raise en in the clk after the block-completing strobe; the block-completing sample of block 1 produces no out_valid.
REQ-021 SHALL keep updating mean every 1024 samples in RUN, without gaps and without dropping samples.
REQ-022 SHALL hold all state when adc_valid=0; out_valid is low in every cycle not directly following an accepted RUN sample.

Reset
REQ-023 SHALL, while rst=1 at a clk edge, set data_out=0, out_valid=0, en=0, mean_out=0, sat_flag=0, sum=0, counter=0, state=ACQ; rst has priority over adc_valid.
REQ-024 SHALL, when rst is asserted mid-block or in RUN, discard the partial sum and require 1024 fresh samples before en rises again.

Verification
REQ-025 Reset: rst high 3 clks with adc_valid toggling -> all outputs 0, en 0, no out_valid.
REQ-026 Constant 2048, 1024 strobes every 20 clks -> en=1 one clk after strobe 1024, mean_out=2048; next strobes give data_out=0 with out_valid 1 clk later.
REQ-027 Square wave 3000/1000, 50% duty, period 64 samples, after 1024 samples -> mean_out=2000, data_out alternates +1000/-1000, sat_flag=0.
REQ-028 1024 zeros, then 4095 -> data_out=2047, sat_flag=1 and stays 1 after samples return to 0.
REQ-029 rst pulse after sample 500 of block 1 -> en stays 0 until 1024 further strobes; mean equals the post-reset data only.
REQ-030 adc_valid every clk, ramp 0..1023 repeated -> mean_out=511 after each block, one out_valid per input in RUN, no sample lost at the block boundary.

Source files
------------

// File: rtl/dc_offset_remover.sv
// DC offset remover: estimates the mean of the unsigned ADC stream over
// fixed blocks of 2^BLOCK_LOG2 samples and subtracts the latest completed
// estimate from every subsequent sample. The result is a saturated signed
// output. Output is suppressed until the first block estimate exists.
module dc_offset_remover #(
    parameter int DATA_WIDTH = 12,
    parameter int BLOCK_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  en,
    output logic [DATA_WIDTH-1:0] mean_out,
    output logic                  sat_flag
);

    localparam int SUM_W = DATA_WIDTH + BLOCK_LOG2;

    typedef enum logic {
        ACQ = 1'b0,
        RUN = 1'b1
    } state_t;

    state_t                  state_q;
    logic [BLOCK_LOG2-1:0]   cnt_q;
    logic [SUM_W-1:0]        sum_q;
    logic [DATA_WIDTH-1:0]   mean_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    valid_q;
    logic                    sat_q;

    logic [SUM_W-1:0]        sum_d;
    logic                    block_done;
    logic signed [DATA_WIDTH:0] diff;
    logic                    clamp;
    logic [DATA_WIDTH-1:0]   data_d;

    // Running sum including the current sample, block boundary detect,
    // and the saturated difference against the mean held before this cycle.
    always_comb begin
        sum_d      = sum_q + SUM_W'(adc_data);
        block_done = (cnt_q == '1);
        diff       = $signed({1'b0, adc_data}) - $signed({1'b0, mean_q});
        // The two top bits disagree exactly when diff is outside the
        // DATA_WIDTH-bit signed range.
        clamp      = (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]);
        data_d     = diff[DATA_WIDTH-1:0];
        if (clamp) begin
            data_d = diff[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    // Acquisition/run state machine with accumulator, mean and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACQ;
            cnt_q   <= '0;
            sum_q   <= '0;
            mean_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (adc_valid) begin
                cnt_q <= cnt_q + BLOCK_LOG2'(1);
                if (block_done) begin
                    // Floor division by the block length; sum restarts so
                    // the next block begins with the very next sample.
                    mean_q  <= sum_d[SUM_W-1:BLOCK_LOG2];
                    sum_q   <= '0;
                    state_q <= RUN;
                end else begin
                    sum_q <= sum_d;
                end
                if (state_q == RUN) begin
                    data_q  <= data_d;
                    valid_q <= 1'b1;
                    if (clamp) begin
                        sat_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign en        = (state_q == RUN);
    assign mean_out  = mean_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_dc_offset_remover.sv
// Self-checking bench for dc_offset_remover: a block-averaging reference
// model (queue of the current block's samples) predicts every output.
module tb_dc_offset_remover;

    localparam int DW    = 12;
    localparam int BL    = 10;
    localparam int BLOCK = 1 << BL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          en;
    logic [DW-1:0] mean_out;
    logic          sat_flag;

    dc_offset_remover #(.DATA_WIDTH(DW), .BLOCK_LOG2(BL)) dut (
        .clk       (clk),
        .rst       (rst),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .en        (en),
        .mean_out  (mean_out),
        .sat_flag  (sat_flag)
    );

    always #2.5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_mean;
    bit m_en;
    bit m_sat;
    bit m_ov;
    int m_do;
    int blk[$];

    task automatic model_reset();
        blk.delete();
        m_mean = 0;
        m_en   = 1'b0;
        m_sat  = 1'b0;
        m_ov   = 1'b0;
        m_do   = 0;
    endtask

    task automatic model_step(input int v);
        int d;
        int s;
        m_ov = m_en;
        if (m_en) begin
            d = v - m_mean;
            if (d > 2047) begin
                d = 2047;
                m_sat = 1'b1;
            end else if (d < -2048) begin
                d = -2048;
                m_sat = 1'b1;
            end
            m_do = d;
        end
        blk.push_back(v);
        if (blk.size() == BLOCK) begin
            s = 0;
            foreach (blk[k]) s += blk[k];
            m_mean = s / BLOCK;
            m_en   = 1'b1;
            blk.delete();
        end
    endtask

    function automatic logic [26:0] exp_pack();
        logic [11:0] d12;
        logic [11:0] mn;
        d12 = m_do[11:0];
        mn  = m_mean[11:0];
        return {m_ov, d12, m_en, mn, m_sat};
    endfunction

    function automatic logic [26:0] dut_pack();
        return {out_valid, data_out, en, mean_out, sat_flag};
    endfunction

    // One accepted sample; leaves time at posedge+1 so strobes can chain.
    task automatic drive(input int v);
        adc_data  = v[DW-1:0];
        adc_valid = 1'b1;
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
        model_step(v);
        $display("tx in=%0d out_valid=%0b data_out=%0d en=%0b mean=%0d",
                 v, out_valid, $signed(data_out), en, mean_out);
    endtask

    task automatic idle_cycle();
        adc_valid = 1'b0;
        @(posedge clk);
        #1;
        m_ov = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        adc_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst       = 1'b1;
            adc_valid = i[0] ? 1'b0 : 1'b1;
            adc_data  = 12'(($urandom_range(0, 4095)));
            @(posedge clk);
            #1;
            model_reset();
            n_vec++;
            if (dut_pack() !== exp_pack()) begin
                n_err++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, dut_pack(), exp_pack());
            end
        end
        rst       = 1'b0;
        adc_valid = 1'b0;
    endtask

    task automatic test_constant();
        do_reset();
        for (int i = 0; i < BLOCK + 4; i++) begin
            drive(2048);
            n_vec++;
            if (dut_pack() !== exp_pack()) begin
                n_err++;
                $display("FAIL const[%0d] got=%h exp=%h", i, dut_pack(), exp_pack());
            end
            for (int g = 0; g < 19; g++) begin
                idle_cycle();
                n_vec++;
                if (dut_pack() !== exp_pack()) begin
                    n_err++;
                    $display("FAIL const_idle[%0d] got=%h exp=%h", i, dut_pack(), exp_pack());
                end
            end
        end
        n_vec++;
        if (mean_out !== 12'd2048) begin
            n_err++;
            $display("FAIL const_mean got=%0d exp=2048", mean_out);
        end
    endtask

    task automatic test_square();
        int v;
        do_reset();
        for (int i = 0; i < BLOCK + 128; i++) begin
            v = ((i / 32) % 2 == 0) ? 3000 : 1000;
            drive(v);
            n_vec++;
            if (dut_pack() !== exp_pack()) begin
                n_err++;
                $display("FAIL square[%0d] got=%h exp=%h", i, dut_pack(), exp_pack());
            end
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        n_vec++;
        if (mean_out !== 12'd2000 || sat_flag !== 1'b0) begin
            n_err++;
            $display("FAIL square_final mean=%0d sat=%0b exp mean=2000 sat=0", mean_out, sat_flag);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < BLOCK + 6; i++) begin
            drive((i == BLOCK) ? 4095 : 0);
            n_vec++;
            if (dut_pack() !== exp_pack()) begin
                n_err++;
                $display("FAIL sat_hi[%0d] got=%h exp=%h", i, dut_pack(), exp_pack());
            end
        end
        n_vec++;
        if (sat_flag !== 1'b1) begin
            n_err++;
            $display("FAIL sat_sticky got=%0b exp=1", sat_flag);
        end
        do_reset();
        for (int i = 0; i < BLOCK + 2; i++) begin
            drive((i < BLOCK) ? 4095 : 0);
            n_vec++;
            if (dut_pack() !== exp_pack()) begin
                n_err++;
                $display("FAIL sat_lo[%0d] got=%h exp=%h", i, dut_pack(), exp_pack());
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive(int'($urandom_range(2500, 4095)));
            n_vec++;
            if (dut_pack() !== exp_pack()) begin
                n_err++;
                $display("FAIL midrst_pre[%0d] got=%h exp=%h", i, dut_pack(), exp_pack());
            end
        end
        // Reset wins over a simultaneous strobe.
        rst       = 1'b1;
        adc_valid = 1'b1;
        adc_data  = 12'd4095;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        adc_valid = 1'b0;
        model_reset();
        n_vec++;
        if (dut_pack() !== exp_pack()) begin
            n_err++;
            $display("FAIL midrst_pulse got=%h exp=%h", dut_pack(), exp_pack());
        end
        for (int i = 0; i < BLOCK + 8; i++) begin
            drive(int'($urandom_range(0, 1500)));
            n_vec++;
            if (dut_pack() !== exp_pack()) begin
                n_err++;
                $display("FAIL midrst_post[%0d] got=%h exp=%h", i, dut_pack(), exp_pack());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2 * BLOCK + 64; i++) begin
            drive(int'($urandom_range(0, 4095)));
            n_vec++;
            if (dut_pack() !== exp_pack()) begin
                n_err++;
                $display("FAIL random[%0d] got=%h exp=%h", i, dut_pack(), exp_pack());
            end
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3 * BLOCK; i++) begin
            drive(i % BLOCK);
            n_vec++;
            if (dut_pack() !== exp_pack()) begin
                n_err++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, dut_pack(), exp_pack());
            end
        end
        n_vec++;
        if (mean_out !== 12'd511) begin
            n_err++;
            $display("FAIL b2b_mean got=%0d exp=511", mean_out);
        end
        idle_cycle();
        n_vec++;
        if (dut_pack() !== exp_pack()) begin
            n_err++;
            $display("FAIL b2b_tail got=%h exp=%h", dut_pack(), exp_pack());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_constant();
        test_square();
        test_saturation();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
